inst_sram_axi_bridge: RTL
=========================

// Module: inst_sram_axi_bridge
// PURPOSE
// Instruction-side bridge between the fetch stage's SRAM-like port and a single-ID AXI3/4 read channel.
// Sits directly upstream of the IF stage:
//   - accepts inst_sram requests (req/addr_ok);
//   - issues single-beat AXI AR transactions;
//   - returns instruction words on data_ok, strictly in request order.
// Supports up to MAX_OUTST accepted-but-unanswered reads so pre-IF can overlap fetches.
// PARAMETERS
// MAX_OUTST   2      max accepted requests without data_ok (1..3); counter width 2 bits
// ARID_VAL    4'h0   constant value driven on arid
// PORTS
// clk               in   1   clock
// reset             in   1   synchronous, active-high reset
// inst_sram_req     in   1   fetch request valid
// inst_sram_wr      in   1   write flag; must be 0, write requests never accepted
// inst_sram_size    in   2   log2 bytes (2'b10 = word)
// inst_sram_addr    in   32  fetch byte address
// inst_sram_addr_ok out  1   request accepted this cycle
// inst_sram_data_ok out  1   rdata valid this cycle (one pulse per accepted request)
// inst_sram_rdata   out  32  returned instruction word
// arid              out  4   = ARID_VAL
// araddr            out  32  read address
// arlen             out  8   = 0 (single beat)
// arsize            out  3   = {1'b0, latched size}
// arburst           out  2   = 2'b01 INCR
// arvalid           out  1   AR valid
// arready           in   1   AR ready
// rid               in   4   ignored (single ID, in-order)
// rdata             in   32  read data
// rresp             in   2   ignored; data returned regardless of response
// rlast             in   1   ignored (arlen=0)
// rvalid            in   1   R valid
// rready            out  1   R ready
// BEHAVIOUR
// - Reset values: arvalid=0, rready=0, data_ok=0, rdata=0, araddr=0, arsize=0, outstanding cnt=0,
//   AR FSM=AR_IDLE. addr_ok is forced 0 while reset is high.
// - AR FSM states: AR_IDLE, AR_SEND.
//   - AR_IDLE -> AR_SEND on addr_ok; same edge latches araddr<=inst_sram_addr and arsize<={0,inst_sram_size}.
//   - In AR_SEND, arvalid=1 and address/size are held stable until arready. AR_SEND -> AR_IDLE on arvalid&arready.
// - addr_ok is combinational: inst_sram_req & ~inst_sram_wr & (state==AR_IDLE) & (cnt<MAX_OUTST).
//   Minimum gap between consecutive accepts: 2 cycles (accept cycle, then AR cycle).
// - Outstanding count cnt:
//   - +1 on addr_ok;
//   - -1 on R handshake (rvalid&rready);
//   - both in same cycle -> unchanged.
//   - Never exceeds MAX_OUTST, never underflows.
// - rready is registered: rready <= (cnt_next != 0).
//   An R beat while cnt==0 cannot be accepted (rready=0).
// - Read-data latency is 1 cycle: on an R handshake at edge T, data_ok=1 and inst_sram_rdata=rdata during
//   cycle T+1. data_ok is 0 otherwise; rdata holds its last value.
// - Best-case request-to-data: addr_ok cycle 0, arvalid cycle 1, rvalid cycle 2, data_ok cycle 3.
// - Every accepted request receives exactly one data_ok, in acceptance order. The bridge never cancels.
//   Flush discarding is done downstream by IF's cancel logic.
// - reset mid-transaction clears all state immediately; in-flight AXI beats are not tracked (SoC-wide reset).
// - inst_sram_wr=1 with req: addr_ok stays 0 indefinitely (illegal; bench assertion).
// TESTING
// 1. Single fetch at addr 0x1c000000, arready/rvalid immediate, rdata 0x02800c0c ->
//    addr_ok cyc0, arvalid cyc1 with araddr 0x1c000000 arsize 3'b010, data_ok cyc3 with 0x02800c0c.
// 2. req held high, rvalid withheld -> two accepts (0x1c000000, 0x1c000004), third addr_ok stays 0 with cnt=2.
//    Releasing one R beat -> third accept the next cycle.
// 3. arready low 5 cycles -> arvalid/araddr stable all 5 cycles, no new addr_ok.
//    Transitions to AR_IDLE after the handshake.
// 4. R beat and new addr_ok in same cycle at cnt=1 -> cnt stays 1. Data order matches request order.
// 5. reset asserted with cnt=2 and arvalid high -> next cycle arvalid=0, rready=0, data_ok=0, cnt=0.
//    A fresh fetch after reset completes normally.
// 6. rresp=2'b10 on a beat -> data_ok still pulses with rdata passed through. req with wr=1 -> addr_ok never asserts.

Source files
------------

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch bridge: SRAM-like request/data_ok port to a single-ID, single-beat AXI read channel.
// Requests are answered strictly in order; up to MAX_OUTST reads may be in flight.
module inst_sram_axi_bridge #(
  parameter int          MAX_OUTST = 2,
  parameter logic [3:0]  ARID_VAL  = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  ar_state_t   r_state;
  logic [1:0]  r_cnt;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_rready;
  logic        r_data_ok;
  logic [31:0] r_rdata;

  logic        w_addr_ok;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic [1:0]  w_cnt_next;
  logic        w_unused;

  // Single ID and arlen=0: ordering and beat boundaries are implicit, response is not acted on.
  assign w_unused = ^{rid, rresp, rlast};

  assign w_addr_ok = ~reset & inst_sram_req & ~inst_sram_wr &
                     (r_state == AR_IDLE) & (r_cnt < MAX_CNT);
  assign w_ar_hs   = r_arvalid & arready;
  assign w_r_hs    = rvalid & r_rready;

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_addr_ok, w_r_hs})
      2'b10:   w_cnt_next = r_cnt + 2'd1;
      2'b01:   w_cnt_next = r_cnt - 2'd1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // AR channel FSM: one accepted request is held on AR until the slave takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= AR_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= 32'h0;
      r_arsize  <= 3'b000;
    end else begin
      case (r_state)
        AR_IDLE: begin
          if (w_addr_ok) begin
            r_state   <= AR_SEND;
            r_arvalid <= 1'b1;
            r_araddr  <= inst_sram_addr;
            r_arsize  <= {1'b0, inst_sram_size};
          end
        end
        AR_SEND: begin
          if (w_ar_hs) begin
            r_state   <= AR_IDLE;
            r_arvalid <= 1'b0;
          end
        end
        default: begin
          r_state   <= AR_IDLE;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding tracking and R return path; rready only while something is owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 2'd0;
      r_rready  <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_rready  <= (w_cnt_next != 2'd0);
      r_data_ok <= w_r_hs;
      if (w_r_hs) r_rdata <= rdata;
    end
  end

  assign inst_sram_addr_ok = w_addr_ok;
  assign inst_sram_data_ok = r_data_ok;
  assign inst_sram_rdata   = r_rdata;
  assign arid              = ARID_VAL;
  assign araddr            = r_araddr;
  assign arlen             = 8'd0;
  assign arsize            = r_arsize;
  assign arburst           = 2'b01;
  assign arvalid           = r_arvalid;
  assign rready            = r_rready;

endmodule
